// File: rtl/ca_gen_scheduler.sv
// Purpose: sequences one CA generation (index sweep, commit strobe, load/ack handoff, paced hold) with run/step/limit control.
// Latency: N+2 cycles from start (run/step sampled in IDLE) to load rising; HOLD adds the selected pacing period plus one cycle.
// Backpressure: load is held in HANDOFF until ack is sampled high; nothing advances while the consumer stalls.
module ca_gen_scheduler #(
    parameter int N     = 512,
    parameter int IDX_W = 10,
    parameter int GEN_W = 16,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    input  logic [1:0]       rate_sel,
    input  logic [GEN_W-1:0] gen_limit,
    input  logic             ack,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W-1:0] index_next,
    output logic             update,
    output logic             load,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SWEEP,
        S_COMMIT,
        S_HANDOFF,
        S_HOLD
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] PER_1    = DIV_ONE << (DIV_W - 4);
    localparam logic [DIV_W-1:0] PER_2    = DIV_ONE << (DIV_W - 2);
    localparam logic [DIV_W-1:0] PER_3    = {DIV_W{1'b1}};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             update_q, update_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;
    logic [DIV_W-1:0] pace_q, pace_d;
    logic [DIV_W-1:0] period;
    logic [GEN_W-1:0] gen_inc;

    assign gen_inc = gen_count_q + GEN_W'(1);

    // Next cell index: counts up only while sweeping, otherwise parks at the first cell.
    always_comb begin
        index_next = IDX_ONE;
        if (state_q == S_SWEEP && index_q < IDX_LAST) begin
            index_next = index_q + IDX_ONE;
        end
    end

    // Pacing period lookup; only consumed on the transition into HOLD.
    always_comb begin
        period = '0;
        case (rate_sel)
            2'd1:    period = PER_1;
            2'd2:    period = PER_2;
            2'd3:    period = PER_3;
            default: period = '0;
        endcase
    end

    // Next-state and registered-output logic for the generation sequencer.
    always_comb begin
        state_d     = state_q;
        index_d     = index_next;
        update_d    = 1'b0;
        load_d      = load_q;
        done_d      = done_q;
        gen_count_d = gen_count_q;
        pace_d      = pace_q;
        case (state_q)
            S_IDLE: begin
                // clear in the same cycle as a start re-arms a finished run before it is checked
                if (clear) begin
                    gen_count_d = '0;
                    done_d      = 1'b0;
                end
                if ((run || step) && (!done_q || clear)) begin
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (index_q == IDX_LAST) begin
                    state_d  = S_COMMIT;
                    update_d = 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = S_HANDOFF;
                load_d  = 1'b1;
            end
            S_HANDOFF: begin
                if (ack) begin
                    load_d      = 1'b0;
                    gen_count_d = gen_inc;
                    if (gen_limit != '0 && gen_inc == gen_limit) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        pace_d  = period;
                    end
                end
            end
            S_HOLD: begin
                if (pace_q == '0) begin
                    state_d = run ? S_SWEEP : S_IDLE;
                end else begin
                    pace_d = pace_q - DIV_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any sweep or handshake immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= IDX_ONE;
            update_q    <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gen_count_q <= '0;
            pace_q      <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            update_q    <= update_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gen_count_q <= gen_count_d;
            pace_q      <= pace_d;
        end
    end

    assign index     = index_q;
    assign update    = update_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_count_q;

endmodule
